// File: rtl/frame_minmax8_pkg.sv
// frame_minmax8_pkg
//   Shared definitions for the frame min/max statistics stage:
//   - IDX_W_DEF : default width of the sample-index fields
//   - state_t   : frame FSM encoding (2'd3 is unused and recovers to IDLE)
package frame_minmax8_pkg;

    localparam int IDX_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/frame_minmax8_cmp8bit.sv
// cmp8bit
//   Unsigned 8-bit magnitude comparator. Bit 0 is the MSB.
//   Ports:
//     a, b     : operands [0:7]
//     ahigher  : a > b
//     alower   : a < b
//     asame    : a == b
//   Exactly one flag is high for any operand pair.
module cmp8bit (
    input  logic [0:7] a,
    input  logic [0:7] b,
    output logic       ahigher,
    output logic       alower,
    output logic       asame
);

    // [0:7] keeps bit 0 as the leftmost (most significant) bit, so the
    // relational operators give the intended unsigned ordering directly.
    assign ahigher = (a > b);
    assign alower  = (a < b);
    assign asame   = (a == b);

endmodule

// File: rtl/frame_minmax8.sv
// frame_minmax8
//   Streaming frame statistics: tracks max/min (first-occurrence index),
//   sample count and overflow over a frame delimited by in_last, then
//   presents the result on a valid/ready port.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     in_valid/in_ready  : sample handshake
//     in_data [0:7]      : unsigned sample, bit 0 = MSB
//     in_last            : final sample of the frame (qualified by in_valid)
//     out_valid/out_ready: result handshake
//     out_max, out_min   : frame extremes, bit 0 = MSB
//     out_max_idx/_min_idx: first-occurrence indices (all-ones past capacity)
//     out_count          : samples in frame, saturating at 2**IDX_W
//     out_ovf            : frame exceeded 2**IDX_W samples
module frame_minmax8
    import frame_minmax8_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:7]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:7]       out_max,
    output logic [0:7]       out_min,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_ovf
);

    localparam logic [IDX_W:0] CAP = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [0:7]       r_max, r_min, w_max_nxt, w_min_nxt;
    logic [IDX_W-1:0] r_max_idx, r_min_idx, w_max_idx_nxt, w_min_idx_nxt;
    logic [IDX_W:0]   r_count, w_count_nxt;
    logic             r_ovf, w_ovf_nxt;

    logic [0:7]       r_out_max, r_out_min;
    logic [IDX_W-1:0] r_out_max_idx, r_out_min_idx;
    logic [IDX_W:0]   r_out_count;
    logic             r_out_ovf;

    logic             w_in_ready, w_accept, w_load_out;
    logic             w_max_hi, w_max_lo, w_max_same;
    logic             w_min_hi, w_min_lo, w_min_same;
    logic             w_upd_max, w_upd_min;
    logic [IDX_W-1:0] w_idx;

    cmp8bit u_cmp_max (
        .a       (in_data),
        .b       (r_max),
        .ahigher (w_max_hi),
        .alower  (w_max_lo),
        .asame   (w_max_same)
    );

    cmp8bit u_cmp_min (
        .a       (in_data),
        .b       (r_min),
        .ahigher (w_min_hi),
        .alower  (w_min_lo),
        .asame   (w_min_same)
    );

    // Only a clean one-hot result updates, so ties keep the first occurrence.
    assign w_upd_max = w_max_hi & ~w_max_lo & ~w_max_same;
    assign w_upd_min = w_min_lo & ~w_min_hi & ~w_min_same;

    assign w_in_ready = (r_state == IDLE) || (r_state == ACCUM);
    assign w_accept   = in_valid && w_in_ready;
    assign w_load_out = w_accept && in_last;

    // r_count equals the number of beats already taken until it saturates;
    // from then on every beat is past capacity and records all-ones.
    assign w_idx = (r_count == CAP) ? {IDX_W{1'b1}} : r_count[IDX_W-1:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_max_nxt     = r_max;
        w_min_nxt     = r_min;
        w_max_idx_nxt = r_max_idx;
        w_min_idx_nxt = r_min_idx;
        w_count_nxt   = r_count;
        w_ovf_nxt     = r_ovf;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_max_nxt     = in_data;
                    w_min_nxt     = in_data;
                    w_max_idx_nxt = '0;
                    w_min_idx_nxt = '0;
                    w_count_nxt   = ONE;
                    w_ovf_nxt     = 1'b0;
                    w_state_nxt   = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (w_upd_max) begin
                        w_max_nxt     = in_data;
                        w_max_idx_nxt = w_idx;
                    end
                    if (w_upd_min) begin
                        w_min_nxt     = in_data;
                        w_min_idx_nxt = w_idx;
                    end
                    if (r_count == CAP) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_count_nxt = r_count + ONE;
                    end
                    if (in_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max         <= '0;
            r_min         <= '0;
            r_max_idx     <= '0;
            r_min_idx     <= '0;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            r_out_max     <= '0;
            r_out_min     <= '0;
            r_out_max_idx <= '0;
            r_out_min_idx <= '0;
            r_out_count   <= '0;
            r_out_ovf     <= 1'b0;
        end else begin
            r_max     <= w_max_nxt;
            r_min     <= w_min_nxt;
            r_max_idx <= w_max_idx_nxt;
            r_min_idx <= w_min_idx_nxt;
            r_count   <= w_count_nxt;
            r_ovf     <= w_ovf_nxt;
            // Result registers capture the final beat's updated values on
            // the way into DONE and then hold until the next frame ends.
            if (w_load_out) begin
                r_out_max     <= w_max_nxt;
                r_out_min     <= w_min_nxt;
                r_out_max_idx <= w_max_idx_nxt;
                r_out_min_idx <= w_min_idx_nxt;
                r_out_count   <= w_count_nxt;
                r_out_ovf     <= w_ovf_nxt;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == DONE);
    assign out_max     = r_out_max;
    assign out_min     = r_out_min;
    assign out_max_idx = r_out_max_idx;
    assign out_min_idx = r_out_min_idx;
    assign out_count   = r_out_count;
    assign out_ovf     = r_out_ovf;

endmodule

// File: tb/tb_frame_minmax8.sv
module tb_frame_minmax8;

    localparam int IDX_W = 4;
    localparam int CAP   = 1 << IDX_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [0:7]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [0:7]       out_max;
    logic [0:7]       out_min;
    logic [IDX_W-1:0] out_max_idx;
    logic [IDX_W-1:0] out_min_idx;
    logic [IDX_W:0]   out_count;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]       mx;
        logic [7:0]       mn;
        logic [IDX_W-1:0] mxi;
        logic [IDX_W-1:0] mni;
        logic [IDX_W:0]   cnt;
        logic             ovf;
    } res_t;

    frame_minmax8 #(.IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_max_idx (out_max_idx),
        .out_min_idx (out_min_idx),
        .out_count   (out_count),
        .out_ovf     (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t dut_res();
        res_t r;
        r.mx  = out_max;
        r.mn  = out_min;
        r.mxi = out_max_idx;
        r.mni = out_min_idx;
        r.cnt = out_count;
        r.ovf = out_ovf;
        return r;
    endfunction

    function automatic res_t mk(input logic [7:0] mx, input logic [7:0] mn,
                                input int mxi, input int mni, input int cnt,
                                input bit ovf);
        res_t r;
        r.mx  = mx;
        r.mn  = mn;
        r.mxi = IDX_W'(mxi);
        r.mni = IDX_W'(mni);
        r.cnt = (IDX_W+1)'(cnt);
        r.ovf = ovf;
        return r;
    endfunction

    // Reference: extremes of the whole frame, index of their first
    // occurrence (all-ones when that lies beyond capacity), clamped count.
    function automatic res_t model(input logic [7:0] s[$]);
        logic [7:0] mxq[$];
        logic [7:0] mnq[$];
        int         fmx[$];
        int         fmn[$];
        int         len;
        int         imx;
        int         imn;
        mxq = s.max();
        mnq = s.min();
        fmx = s.find_first_index(x) with (x == mxq[0]);
        fmn = s.find_first_index(x) with (x == mnq[0]);
        len = s.size();
        imx = (fmx[0] >= CAP) ? CAP - 1 : fmx[0];
        imn = (fmn[0] >= CAP) ? CAP - 1 : fmn[0];
        return mk(mxq[0], mnq[0], imx, imn, (len > CAP) ? CAP : len, len > CAP);
    endfunction

    task automatic send_frame(input logic [7:0] s[$], input bit gaps);
        for (int i = 0; i < s.size(); i++) begin
            int ng;
            ng = 0;
            if (gaps) begin
                while (($urandom_range(0, 1) == 0) && (ng < 6)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                    @(posedge clk);
                    ng++;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = (i == s.size() - 1);
            @(posedge clk);
        end
    endtask

    task automatic release_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_hs out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dut_res() !== '0) begin
            errors++;
            $display("FAIL reset in_ready=%b out_valid=%b res=%h required 1/0/0", in_ready, out_valid, dut_res());
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        res_t exp;
        s = '{8'd5, 8'd200, 8'd3, 8'd200, 8'd3};
        send_frame(s, 1'b0);
        release_in();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        exp = mk(8'd200, 8'd3, 1, 2, 5, 1'b0);
        checks++;
        if (dut_res() !== exp) begin
            errors++;
            $display("FAIL basic_result got %h required %h", dut_res(), exp);
        end
        handshake("basic");
    endtask

    task automatic test_single();
        logic [7:0] s[$];
        res_t exp;
        s = '{8'h7F};
        send_frame(s, 1'b0);
        release_in();
        exp = mk(8'h7F, 8'h7F, 0, 0, 1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || dut_res() !== exp) begin
            errors++;
            $display("FAIL single_result out_valid=%b got %h required 1/%h", out_valid, dut_res(), exp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_in_ready got %b required 0", in_ready);
        end
        handshake("single");
    endtask

    task automatic test_hold();
        logic [7:0] s[$];
        res_t exp;
        for (int i = 0; i < 6; i++) s.push_back(8'($urandom));
        exp = model(s);
        send_frame(s, 1'b0);
        release_in();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (dut_res() !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got %h v=%b r=%b required %h v=1 r=0", c, dut_res(), out_valid, in_ready, exp);
            end
            @(negedge clk);
        end
        handshake("hold");
        checks++;
        if (dut_res() !== exp) begin
            errors++;
            $display("FAIL hold_retain got %h required %h", dut_res(), exp);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s[$];
        res_t exp;
        res_t mdl;
        for (int i = 0; i < 18; i++) s.push_back(8'($urandom_range(1, 254)));
        s[3]  = 8'h00;
        s[17] = 8'hFF;
        exp = mk(8'hFF, 8'h00, 15, 3, 16, 1'b1);
        mdl = model(s);
        send_frame(s, 1'b0);
        release_in();
        checks++;
        if (dut_res() !== exp) begin
            errors++;
            $display("FAIL overflow_result got %h required %h", dut_res(), exp);
        end
        checks++;
        if (dut_res() !== mdl) begin
            errors++;
            $display("FAIL overflow_model got %h required %h", dut_res(), mdl);
        end
        handshake("overflow");
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        res_t exp;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_res() !== '0) begin
            errors++;
            $display("FAIL midreset_state v=%b r=%b res=%h required 0/1/0", out_valid, in_ready, dut_res());
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_output out_valid=%b required 0", out_valid);
            end
        end
        s = '{8'd9, 8'd1};
        send_frame(s, 1'b0);
        release_in();
        exp = mk(8'd9, 8'd1, 0, 1, 2, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || dut_res() !== exp) begin
            errors++;
            $display("FAIL midreset_result v=%b got %h required 1/%h", out_valid, dut_res(), exp);
        end
        handshake("midreset");
    endtask

    task automatic test_gaps();
        logic [7:0] s[$];
        res_t exp;
        s = '{8'd10, 8'd20, 8'd30};
        send_frame(s, 1'b1);
        release_in();
        exp = mk(8'd30, 8'd10, 2, 0, 3, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || dut_res() !== exp) begin
            errors++;
            $display("FAIL gaps_result v=%b got %h required 1/%h", out_valid, dut_res(), exp);
        end
        handshake("gaps");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            logic [7:0] s[$];
            res_t exp;
            int   len;
            bit   narrow;
            len    = $urandom_range(1, 20);
            narrow = 1'($urandom);
            for (int i = 0; i < len; i++)
                s.push_back(narrow ? 8'($urandom_range(0, 3)) : 8'($urandom));
            exp = model(s);
            send_frame(s, 1'($urandom));
            release_in();
            checks++;
            if (out_valid !== 1'b1 || dut_res() !== exp) begin
                errors++;
                $display("FAIL b2b_frame%0d len=%0d v=%b got %h required 1/%h", f, len, out_valid, dut_res(), exp);
            end
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle v=%b r=%b required 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_hold();
        test_overflow();
        test_reset_mid();
        test_gaps();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
